rx_fifo_param: RTL and testbench
================================

Name: rx_fifo_param

Overview:
Parametrised next-generation receive FIFO: single-clock, first-word-fall-through buffer with configurable data width and depth. Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Sits between the receiver deserialiser (writer) and the downstream packet/output-buffer logic (reader).

Parameters:
DATA_WIDTH, 8, bits per entry
DEPTH, 8, number of entries; power of 2, >= 2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
clear  input  1  synchronous flush, active-high
w_enable  input  1  push w_data this cycle
w_data  input  DATA_WIDTH  write data
r_enable  input  1  pop head entry this cycle
r_data  output  DATA_WIDTH  head entry (FWFT); 0 when empty
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: write attempted while full and not popped
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Storage: DEPTH x DATA_WIDTH register array; read/write pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally; separate count register (no extra pointer bit).
- Reset (rst=1, any time, incl. mid-transfer): pointers=0, count=0, overflow=0, underflow=0 immediately; outputs: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 never, so 0), r_data=0. Array contents need not reset.
- clear=1 at an edge: same effect as reset, synchronous; overrides w_enable/r_enable that cycle (no push, no pop, no error flag set).
- Accepted push: w_enable=1 and (!full or accepted pop same cycle). Writes mem[wptr], wptr++.
- Accepted pop: r_enable=1 and !empty. rptr++.
- count: +1 push only, -1 pop only, unchanged both/neither.
- Full + w_enable + r_enable: both accepted, count stays DEPTH, no overflow.
- Full + w_enable, no r_enable: write dropped, data and pointers unchanged, overflow<=1.
- Empty + r_enable (with or without w_enable): pop ignored, underflow<=1; simultaneous write still accepted (count -> 1).
- overflow/underflow stay 1 until rst or clear.
- r_data = mem[rptr] when !empty else 0; combinational from registered pointer/array, so a word written at edge N is visible on r_data after edge N (latency 1 cycle write-to-visible). Popping at edge N shows next entry after edge N.
- All flags combinational decodes of registered count; update in the cycle following the causing edge; no glitching on same-cycle push+pop.

Test Plan:
- Reset: DATA_WIDTH=8, DEPTH=8, assert rst mid-cycle with 3 entries held -> count=0, empty=1, almost_empty=1, r_data=0 without waiting for clk.
- Fill/drain: push 0x11..0x88 (8 writes) -> full=1, almost_full from 6th write, count=8; pop 8 -> r_data sequence 0x11..0x88, empty=1 after last pop, pointers wrapped to 0.
- Full boundary: at count=8 push 0x99 with no pop -> overflow=1, count=8, next pops still 0x11..; at count=8 push 0xAA with pop -> no overflow, count=8, 0xAA read 8th.
- Empty boundary: empty, r_enable=1 + w_enable=1 w_data=0x5A -> underflow=1, count=1, r_data=0x5A next cycle.
- Wrap stress: 20 cycles continuous push+pop at count=3 -> count stays 3, data order preserved across pointer wrap, no error flags.
- Clear: count=5, overflow=1, clear=1 with w_enable=1 -> count=0, overflow=0, empty=1, written word discarded.

Source files
------------

// File: rtl/rx_fifo_param.sv
// Single-clock first-word-fall-through receive FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky error flags and flush.
module rx_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   w_enable,
    input  logic [DATA_WIDTH-1:0]  w_data,
    input  logic                   r_enable,
    output logic [DATA_WIDTH-1:0]  r_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop;

    assign empty        = (count_q == '0);
    assign full         = (count_q == FULL_CNT);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign r_data       = empty ? '0 : mem_q[rptr_q];

    // A pop frees the slot a same-cycle write needs, so a full FIFO still accepts it.
    assign pop  = r_enable && !empty && !clear;
    assign push = w_enable && (!full || pop) && !clear;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear) begin
            wptr_d      = '0;
            rptr_d      = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) wptr_d = wptr_q + PW'(1);
            if (pop)  rptr_d = rptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            if (w_enable && full && !r_enable) overflow_d  = 1'b1;
            if (r_enable && empty)             underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= w_data;
    end

endmodule

// File: tb/tb_rx_fifo_param.sv
// Scoreboarded random and directed bench for rx_fifo_param against a queue model.
module tb_rx_fifo_param;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst, clear, w_enable, r_enable;
    logic [DW-1:0] w_data, r_data;
    logic          empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]    count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf, m_unf;

    rx_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .w_enable(w_enable), .w_data(w_data), .r_enable(r_enable),
        .r_data(r_data), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int n;
        n = mq.size();
        chk({tag, " count"}, 32'(count), 32'(n));
        chk({tag, " empty"}, 32'(empty), 32'(n == 0));
        chk({tag, " full"}, 32'(full), 32'(n == DEPTH));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, " almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(m_unf));
        chk({tag, " r_data"}, 32'(r_data), (n == 0) ? 32'd0 : 32'(mq[0]));
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    // Drive one cycle, advance the model to its post-edge state, then check.
    task automatic step(input bit we, input logic [DW-1:0] wd, input bit re, input bit clr,
                        input string tag);
        bit pop_ok, push_ok;
        w_enable = we;
        w_data   = wd;
        r_enable = re;
        clear    = clr;
        if (clr) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            pop_ok  = re && (mq.size() > 0);
            push_ok = we && ((mq.size() < DEPTH) || pop_ok);
            if (we && mq.size() == DEPTH && !re) m_ovf = 1;
            if (re && mq.size() == 0) m_unf = 1;
            if (pop_ok) exp_q.push_back(mq.pop_front());
            if (push_ok) mq.push_back(wd);
        end
        @(posedge clk);
        #1;
        check_status(tag);
    endtask

    // Monitor: every cycle the DUT offers a head word that is being popped.
    always @(negedge clk) begin
        if (!rst && !clear && r_enable && !empty) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_data: got %0h with no pop expected at %0t", r_data, $time);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (r_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h at %0t", r_data, e, $time);
                end
            end
        end
    end

    initial begin
        rst = 1; clear = 0; w_enable = 0; r_enable = 0; w_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_status("reset");
        rst = 0;

        // Asynchronous reset with entries held
        for (int i = 0; i < 3; i++) step(1, DW'(8'hC0 + i), 0, 0, "pre_rst");
        w_enable = 0; r_enable = 0; clear = 0;
        #2 rst = 1;
        #1 model_reset();
        check_status("async_rst");
        @(posedge clk);
        #1 rst = 0;

        // Fill, overflow, full push+pop, drain
        for (int i = 1; i <= 8; i++) step(1, DW'(8'h11 * i), 0, 0, "fill");
        step(1, 8'h99, 0, 0, "ovf_push");
        step(1, 8'hAA, 1, 0, "full_pushpop");
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, "drain");

        // Empty read with simultaneous write
        step(1, 8'h5A, 1, 0, "empty_rw");
        step(0, 8'h00, 1, 0, "pop_5a");
        step(0, 8'h00, 0, 1, "clr1");

        // Continuous push+pop across pointer wrap
        for (int i = 0; i < 3; i++) step(1, DW'($urandom), 0, 0, "wrap_pre");
        for (int i = 0; i < 20; i++) step(1, DW'($urandom), 1, 0, "wrap");
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, "wrap_drain");

        // Clear with a pending write and overflow set
        for (int i = 0; i < 8; i++) step(1, DW'($urandom), 0, 0, "cfill");
        step(1, 8'hEE, 0, 0, "covf");
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, "cpop");
        step(1, 8'h77, 0, 1, "clear_we");
        step(0, 8'h00, 0, 0, "post_clear");

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(bit'($urandom_range(0, 1)), DW'($urandom), bit'($urandom_range(0, 1)),
                 ($urandom_range(0, 39) == 0), "rand");

        step(0, 8'h00, 0, 0, "final");
        chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
